norm_accum: RTL
===============

NORM_ACCUM -- requirements
Module: norm_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 20, meaning signed width of each input component.
REQ-002 SHALL have parameter NUM_TERMS, default 4, meaning number of accepted samples summed per frame (>=2).
REQ-003 SHALL have derived constant OUT_W = WIDTH+1+clog2(NUM_TERMS), meaning result width.
REQ-004 SHALL have clk  input  1  rising-edge clock; the block has one clock.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have frame_clr  input  1  synchronous abort of the current frame and all in-flight data.
REQ-007 SHALL have mode  input  2  norm select: 0 L1, 1 Linf, 2 approximate L2, 3 reserved.
REQ-008 SHALL have in_valid  input  1  sample present.
REQ-009 SHALL have in_ready  output  1  block can accept a sample.
REQ-010 SHALL have in_real, in_imag  input  WIDTH each  signed two's-complement sample.
REQ-011 SHALL have out_valid  output  1  frame result held.
REQ-012 SHALL have out_ready  input  1  consumer takes result.
REQ-013 SHALL have out_data  output  OUT_W  unsigned frame sum.
REQ-014 SHALL have out_mode  output  2  mode the frame was computed with.

Function
REQ-015 SHALL accept a sample on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL compute unsigned magnitudes ar=|in_real|, ai=|in_imag| in WIDTH bits; -2^(WIDTH-1) SHALL map to 2^(WIDTH-1) with no wrap.
REQ-017 SHALL compute per-sample norm in WIDTH+1 bits: L1 = ar+ai; Linf = max(ar,ai); approx L2 = max + (min >> 1), truncating; mode 3 SHALL behave as L1.
REQ-018 SHALL latch mode at acceptance of the first sample of a frame and use it for all NUM_TERMS samples of that frame; mid-frame changes SHALL be ignored.
REQ-019 SHALL pipeline as two register stages: S1 holds the per-sample norm and a valid bit (updated at the acceptance edge); S2 accumulates (updated the next edge).
REQ-020 SHALL load, not add, the accumulator for the first sample of a frame, so back-to-back frames need no idle cycle.
REQ-021 SHALL, when the NUM_TERMS-th sample reaches S2, register the full sum into out_data, latched mode into out_mode, and set out_valid; latency from last-sample acceptance edge to out_valid high is 2 edges.
REQ-022 SHALL hold out_data, out_mode and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive in_ready = NOT(out_valid AND NOT out_ready); while in_ready=0 both S1 and S2 SHALL freeze.
REQ-024 SHALL clear out_valid on an edge with out_ready=1 unless a new result is written that same edge, in which case out_valid stays 1 with new data.
REQ-025 SHALL never overflow OUT_W: sum of NUM_TERMS worst-case norms fits by construction.
REQ-026 SHALL, on frame_clr=1 at an edge, clear the term counter, S1 valid, accumulator and out_valid, discard any sample presented that edge, and take priority over all other events.
REQ-027 SHALL wrap the term counter from NUM_TERMS-1 to 0 after the last sample of each frame.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force out_valid=0, out_data=0, out_mode=0, term counter=0, S1 valid=0, accumulator=0; in_ready SHALL read 1.
REQ-029 SHALL start a fresh frame on the first acceptance after rst_n deasserts; reset mid-frame SHALL discard the partial sum.

Structure
REQ-030 SHALL place mode encodings (MODE_L1, MODE_LINF, MODE_L2A) in shared package norm_pkg.
REQ-031 SHALL implement the combinational per-sample magnitude/norm (REQ-016, REQ-017) in one sub-module cplx_norm, parameterised by WIDTH.

Verification (WIDTH=20, NUM_TERMS=4)
REQ-032 SHALL check mode 0, samples (3,-4),(-1,2),(0,0),(-5,-5) back-to-back -> out_data=20, out_valid 2 edges after the 4th acceptance.
REQ-033 SHALL check same samples, mode 1 -> 11; mode 2 -> 14 (terms 5,2,0,7).
REQ-034 SHALL check four samples (-524288,-524288), mode 0 -> out_data=4194304, no wrap.
REQ-035 SHALL check out_ready=0 for 5 cycles with result pending -> in_ready=0, out_data stable, second frame resumes without loss and sums correctly.
REQ-036 SHALL check frame_clr after 2 samples, then 4 samples of (1,1) mode 0 -> out_data=8; mode changed to 1 after the first of those samples -> out_mode=0, out_data=8.
REQ-037 SHALL check rst_n pulsed low mid-frame -> outputs zero immediately, next 4 samples form a clean frame.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared definitions for the complex-sample norm accumulator.
// Mode encodings are common to the norm datapath and the frame accumulator.
package norm_pkg;

    typedef enum logic [1:0] {
        MODE_L1   = 2'd0,
        MODE_LINF = 2'd1,
        MODE_L2A  = 2'd2,
        MODE_RSVD = 2'd3
    } norm_mode_e;

endpackage

// File: rtl/cplx_norm.sv
// Combinational per-sample norm of a signed complex value: L1, Linf or
// max + min/2 approximation of L2. The reserved encoding falls back to L1.
module cplx_norm
    import norm_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic signed [WIDTH-1:0] in_real_i,
    input  logic signed [WIDTH-1:0] in_imag_i,
    input  logic        [1:0]       mode_i,
    output logic        [WIDTH:0]   norm_o
);

    logic [WIDTH-1:0] ar_s;
    logic [WIDTH-1:0] ai_s;
    logic [WIDTH-1:0] max_s;
    logic [WIDTH-1:0] min_s;

    // Magnitudes held unsigned so the most negative input maps to 2^(WIDTH-1)
    always_comb begin
        ar_s = in_real_i[WIDTH-1] ? $unsigned(-in_real_i) : $unsigned(in_real_i);
        ai_s = in_imag_i[WIDTH-1] ? $unsigned(-in_imag_i) : $unsigned(in_imag_i);
        if (ar_s >= ai_s) begin
            max_s = ar_s;
            min_s = ai_s;
        end else begin
            max_s = ai_s;
            min_s = ar_s;
        end
    end

    // Norm selection
    always_comb begin
        norm_o = {1'b0, ar_s} + {1'b0, ai_s};
        case (mode_i)
            MODE_L1:   norm_o = {1'b0, ar_s} + {1'b0, ai_s};
            MODE_LINF: norm_o = {1'b0, max_s};
            MODE_L2A:  norm_o = {1'b0, max_s} + {2'b00, min_s[WIDTH-1:1]};
            default:   norm_o = {1'b0, ar_s} + {1'b0, ai_s};
        endcase
    end

endmodule

// File: rtl/norm_accum.sv
// Frame accumulator: sums NUM_TERMS per-sample norms through an S1 (norm)
// and S2 (accumulate) pipeline into a held output register with backpressure.
module norm_accum
    import norm_pkg::*;
#(
    parameter  int WIDTH     = 20,
    parameter  int NUM_TERMS = 4,
    localparam int OUT_W     = WIDTH + 1 + $clog2(NUM_TERMS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_clr,
    input  logic        [1:0]       mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [OUT_W-1:0] out_data,
    output logic        [1:0]       out_mode
);

    localparam int                CNT_W    = $clog2(NUM_TERMS);
    localparam int                PAD_W    = OUT_W - WIDTH - 1;
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_TERMS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fmode_q, fmode_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_first_q, s1_first_d;
    logic             s1_last_q, s1_last_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [WIDTH:0]   s1_norm_q, s1_norm_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             done_q, done_d;
    logic [1:0]       dmode_q, dmode_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [1:0]       out_mode_q, out_mode_d;

    logic             run_s;
    logic             accept_s;
    logic             first_s;
    logic [1:0]       eff_mode_s;
    logic [WIDTH:0]   norm_s;
    logic [OUT_W-1:0] norm_ext_s;

    assign run_s      = ~(out_valid_q & ~out_ready);
    assign accept_s   = in_valid & run_s;
    assign first_s    = (cnt_q == CNT_ZERO);
    // The first sample of a frame uses the live mode; the rest use the latched copy
    assign eff_mode_s = first_s ? mode : fmode_q;
    assign norm_ext_s = {{PAD_W{1'b0}}, s1_norm_q};

    cplx_norm #(.WIDTH(WIDTH)) u_norm (
        .in_real_i (in_real),
        .in_imag_i (in_imag),
        .mode_i    (eff_mode_s),
        .norm_o    (norm_s)
    );

    // Next-state for counter, S1, S2 and output stage
    always_comb begin
        cnt_d       = cnt_q;
        fmode_d     = fmode_q;
        s1_valid_d  = s1_valid_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_mode_d   = s1_mode_q;
        s1_norm_d   = s1_norm_q;
        acc_d       = acc_q;
        done_d      = done_q;
        dmode_d     = dmode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        if (frame_clr) begin
            cnt_d       = CNT_ZERO;
            s1_valid_d  = 1'b0;
            acc_d       = {OUT_W{1'b0}};
            done_d      = 1'b0;
            out_valid_d = 1'b0;
        end else if (run_s) begin
            if (accept_s) begin
                cnt_d   = (cnt_q == CNT_LAST) ? CNT_ZERO : cnt_q + CNT_W'(1'b1);
                fmode_d = eff_mode_s;
            end else begin
                cnt_d   = cnt_q;
            end
            s1_valid_d = accept_s;
            s1_first_d = first_s;
            s1_last_d  = (cnt_q == CNT_LAST);
            s1_mode_d  = eff_mode_s;
            s1_norm_d  = norm_s;
            if (s1_valid_q) begin
                acc_d   = s1_first_q ? norm_ext_s : acc_q + norm_ext_s;
                done_d  = s1_last_q;
                dmode_d = s1_mode_q;
            end else begin
                done_d  = 1'b0;
            end
            // A fresh result keeps out_valid high even while the old one is taken
            if (done_q) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_q;
                out_mode_d  = dmode_q;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= CNT_ZERO;
            fmode_q     <= 2'd0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_mode_q   <= 2'd0;
            s1_norm_q   <= {(WIDTH+1){1'b0}};
            acc_q       <= {OUT_W{1'b0}};
            done_q      <= 1'b0;
            dmode_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            out_mode_q  <= 2'd0;
        end else begin
            cnt_q       <= cnt_d;
            fmode_q     <= fmode_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_mode_q   <= s1_mode_d;
            s1_norm_q   <= s1_norm_d;
            acc_q       <= acc_d;
            done_q      <= done_d;
            dmode_q     <= dmode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
        end
    end

    assign in_ready  = run_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;

endmodule
